// File: rtl/cplx_real_sub.sv
// cplx_real_sub: bit-serial borrow-ripple subtractor forming Re = ac - bd.
// Processes one bit per clock, LSB first, using a slice built from two
// half-subtractor cells and a borrow register.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (a = minuend, b = subtrahend)
//   out_valid / out_ready result handshake (diff = (a-b) mod 2^W, borrow = a<b)
module cplx_real_sub #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int unsigned CNT_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       sa_q, sa_d;
    logic [W-1:0]       sb_q, sb_d;
    logic [W-1:0]       sr_q, sr_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               accept_c;
    logic               d1_c, r1_c, d_c, r2_c, bout_c;

    assign accept_c = (state_q == S_IDLE) && in_valid && in_ready_q;

    // One subtractor slice: two half-subtractors plus borrow merge
    assign d1_c   = sa_q[0] ^ sb_q[0];
    assign r1_c   = ~sa_q[0] & sb_q[0];
    assign d_c    = d1_c ^ br_q;
    assign r2_c   = ~d1_c & br_q;
    assign bout_c = r1_c | r2_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept_c) state_d = S_RUN;
            S_RUN:  if (cnt_q == CNT_W'(W - 1)) state_d = S_DONE;
            S_DONE: if (out_valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        sa_d  = sa_q;
        sb_d  = sb_q;
        sr_d  = sr_q;
        br_d  = br_q;
        cnt_d = cnt_q;
        if (accept_c) begin
            sa_d  = a;
            sb_d  = b;
            sr_d  = '0;
            br_d  = 1'b0;
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            sr_d  = {d_c, sr_q[W-1:1]};
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            br_d  = bout_c;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath and handshake registers; in_ready stays low through reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_q        <= '0;
            sb_q        <= '0;
            sr_q        <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sr_q        <= sr_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = sr_q;
    assign borrow    = br_q;

endmodule
